// File: rtl/word_to_int_stream.sv
// Character-stream to integer converter with runtime radix, sign and overflow detection.
// Optional radix prefixes ('$' hex, '%' binary, '#' decimal) are enabled by WORD_TO_INT_PREFIX_EN.
module word_to_int_stream #(
  parameter int DATA     = 32,
  parameter int MAX_LEN  = 32,
  parameter int LEN_BITS = $clog2(MAX_LEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [5:0]      i_base,
  input  logic            i_valid,
  input  logic [7:0]      i_char,
  input  logic            i_last,
  output logic            o_ready,
  output logic            o_valid,
  output logic [DATA-1:0] o_data,
  output logic            o_err,
  output logic            o_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] LEN_SAT = LEN_BITS'(MAX_LEN + 1);
  localparam logic [DATA-1:0]     NEG_LIM = {1'b1, {(DATA-1){1'b0}}};

  // Returns {valid, value}; value is 0..35 for [0-9A-Za-z].
  function automatic logic [6:0] f_digit(input logic [7:0] c);
    logic [7:0] v;
    if (c >= 8'h30 && c <= 8'h39)      v = c - 8'h30;
    else if (c >= 8'h41 && c <= 8'h5A) v = c - 8'h41 + 8'd10;
    else if (c >= 8'h61 && c <= 8'h7A) v = c - 8'h61 + 8'd10;
    else                               return 7'd0;
    return {1'b1, v[5:0]};
  endfunction

  state_t              r_state;
  logic [5:0]          r_base;
  logic [DATA-1:0]     r_acc;
  logic [LEN_BITS-1:0] r_len;
  logic                r_neg, r_err, r_ovf, r_dig;
  logic                r_ready, r_valid, r_err_o, r_ovf_o;
  logic [DATA-1:0]     r_data;
`ifdef WORD_TO_INT_PREFIX_EN
  logic                r_pfx;
  logic                w_pfx_n;
`endif

  logic                w_first, w_accept;
  logic [5:0]          w_base_n;
  logic [DATA-1:0]     w_acc_n;
  logic [LEN_BITS-1:0] w_len_n;
  logic                w_neg_n, w_err_n, w_ovf_n, w_dig_n;
  logic [6:0]          w_dv;
  logic [DATA+5:0]     w_prod;
  logic                w_fin_err, w_fin_ovf;
  logic [DATA-1:0]     w_fin_data;

  assign w_accept = i_valid && r_ready;

  // Next-word state as if the current character is accepted; a new word starts fresh in IDLE.
  always_comb begin
    w_first  = (r_state == S_IDLE);
    w_base_n = w_first ? i_base : r_base;
    w_acc_n  = w_first ? '0 : r_acc;
    w_neg_n  = w_first ? 1'b0 : r_neg;
    w_err_n  = w_first ? 1'b0 : r_err;
    w_ovf_n  = w_first ? 1'b0 : r_ovf;
    w_dig_n  = w_first ? 1'b0 : r_dig;
    w_len_n  = w_first ? LEN_BITS'(1) : ((r_len == LEN_SAT) ? r_len : r_len + 1'b1);
`ifdef WORD_TO_INT_PREFIX_EN
    w_pfx_n  = w_first ? 1'b0 : r_pfx;
`endif
    w_dv     = f_digit(i_char);
    w_prod   = '0;

    if (w_len_n > LEN_MAX) begin
      w_err_n = 1'b1;
    end else if (i_char == 8'h2D) begin
      if (w_first) w_neg_n = 1'b1;
      else         w_err_n = 1'b1;
    end
`ifdef WORD_TO_INT_PREFIX_EN
    else if (i_char == 8'h24 || i_char == 8'h25 || i_char == 8'h23) begin
      if (w_first || (r_len == LEN_BITS'(1) && r_neg && !r_pfx)) begin
        w_pfx_n  = 1'b1;
        w_base_n = (i_char == 8'h24) ? 6'd16 : (i_char == 8'h25) ? 6'd2 : 6'd10;
      end else begin
        w_err_n = 1'b1;
      end
    end
`endif
    else if (!w_dv[6] || w_dv[5:0] >= w_base_n) begin
      w_err_n = 1'b1;
    end else begin
      w_prod  = (DATA+6)'(w_acc_n) * (DATA+6)'(w_base_n) + (DATA+6)'(w_dv[5:0]);
      w_acc_n = w_prod[DATA-1:0];
      w_dig_n = 1'b1;
      if (w_prod[DATA+5:DATA] != '0) w_ovf_n = 1'b1;
    end

    w_fin_err  = w_err_n || !w_dig_n || (w_base_n < 6'd2) || (w_base_n > 6'd36);
    w_fin_ovf  = w_ovf_n || (w_neg_n && (w_acc_n > NEG_LIM));
    w_fin_data = w_neg_n ? -w_acc_n : w_acc_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_acc   <= '0;
      r_len   <= '0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_dig   <= 1'b0;
`ifdef WORD_TO_INT_PREFIX_EN
      r_pfx   <= 1'b0;
`endif
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err_o <= 1'b0;
      r_ovf_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_base <= w_base_n;
            r_acc  <= w_acc_n;
            r_len  <= w_len_n;
            r_neg  <= w_neg_n;
            r_err  <= w_err_n;
            r_ovf  <= w_ovf_n;
            r_dig  <= w_dig_n;
`ifdef WORD_TO_INT_PREFIX_EN
            r_pfx  <= w_pfx_n;
`endif
            if (i_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
              r_data  <= w_fin_data;
              r_err_o <= w_fin_err;
              r_ovf_o <= w_fin_ovf;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err_o;
  assign o_ovf   = r_ovf_o;

endmodule

// File: doc/word_to_int_stream.md
Name: word_to_int_stream

Overview:
- Sequential successor to the compiler's word-to-integer converter.
- Takes one character per cycle from the tokenizer over a valid/ready stream, terminated by a last flag.
- Accumulates the value in a runtime-selectable radix (Forth BASE, 2..36), with optional leading '-' and overflow detection.
- Emits a one-cycle result pulse to the compiler/interpreter dispatch logic.

Parameters:
- DATA, 32, result width in bits.
- MAX_LEN, 32, maximum accepted characters per word, including sign and prefix.
- LEN_BITS, $clog2(MAX_LEN)+1, width of the internal character counter (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_base  in  6  radix, sampled on the first accepted character of a word.
- i_valid  in  1  character valid.
- i_char  in  8  ASCII character.
- i_last  in  1  marks final character of the word; qualified by i_valid.
- o_ready  out  1  block can accept a character this cycle.
- o_valid  out  1  one-cycle result strobe.
- o_data  out  DATA  result, two's complement when negative.
- o_err  out  1  syntax error: bad digit, digit >= base, lone sign/prefix, bad base, or length > MAX_LEN.
- o_ovf  out  1  magnitude overflow.

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous, active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_data=0, o_err=0, o_ovf=0, accumulator=0, length=0, neg=0.
- Handshake: a character is accepted when i_valid && o_ready. o_ready=1 in IDLE and ACCUM, 0 in DONE.
- IDLE:
  - On acceptance, latch base=i_base, clear accumulator and flags, length=1.
  - If i_char=='-', set neg; otherwise process the character as a digit.
  - If i_last, go to DONE; else go to ACCUM.
- ACCUM:
  - Each accepted character is processed as a digit; length increments.
  - Accepting i_last goes to DONE.
- DONE:
  - Lasts exactly one cycle. o_valid=1, o_data/o_err/o_ovf are presented.
  - Returns to IDLE; o_ready returns to 1 the following cycle.
  - Result latency: 1 cycle after the i_last handshake.
- Digit mapping:
  - '0'-'9' map to 0-9; 'A'-'Z' and 'a'-'z' map to 10-35.
  - Any other character, or a digit >= base, sets a sticky err. The accumulator is not updated by that character.
- Arithmetic:
  - acc_next = acc*base + digit, computed in DATA+6 bits.
  - If the upper bits are nonzero, set sticky ovf; acc keeps the low DATA bits (wraps).
  - For neg, ovf is also set when final magnitude > 2^(DATA-1).
  - For non-neg, the final magnitude may be up to 2^DATA-1.
  - o_data = neg ? -acc : acc, taken modulo 2^DATA.
- Error rules:
  - Base < 2 or > 36 gives err.
  - A word consisting only of '-' gives err.
  - A '-' in any position other than the first gives err.
  - Length > MAX_LEN gives err. Later characters are still consumed until i_last; no further accumulation.
  - Errors are sticky within a word and are cleared at the next word's first character.
- Result hold: o_data/o_err/o_ovf hold their values after o_valid until the next DONE. Only o_valid is a pulse.
- Gaps: i_valid low mid-word stalls in ACCUM indefinitely, with no timeout.
- Reset mid-word: the partial word is discarded, no o_valid is produced, and the block restarts in IDLE.
- Simultaneous i_rst and character handshake: reset wins; the character is dropped.
- i_base changes mid-word are ignored.

Optional Feature:
- Macro: WORD_TO_INT_PREFIX_EN.
- With the macro: a first character of '$', '%' or '#' (or one following a leading '-') overrides the latched base with 16, 2 or 10 respectively, for that word only. A prefix with no digits gives err. A prefix in any later position gives err.
- Without the macro: '$', '%' and '#' are ordinary invalid characters and give err.

Test Plan:
- Base 10, stream "1","2","3"(last) -> o_valid one cycle after last, o_data=123, o_err=0, o_ovf=0.
- Base 16, stream "-","f","F"(last) -> o_data=0xFFFFFF01 (-255), o_err=0.
- Base 10, stream "1","2","a"(last) -> o_err=1, and o_valid still pulses exactly once.
- Base 10, DATA=32, stream "4294967296"(last) -> o_ovf=1, o_data=0 (wrapped).
- Base 10, stream "-" then "2147483648"(last) -> o_data=0x80000000, o_ovf=0; "-2147483649" -> o_ovf=1.
- Stream "5","6" with i_rst asserted, then "7"(last) -> o_data=7, and no o_valid for the aborted word.
- With WORD_TO_INT_PREFIX_EN, base 10: "$1F" -> 31; "%101" -> 5; "$"(last) -> o_err=1.
